// File: rtl/uwb_tx_pkg.sv
// Shared types and constants for the UWB transmit serializer.
//   ser_state_t  : serializer FSM states
//   LFSR_TAPS    : keystream LFSR taps (x^8+x^6+x^5+x^4+1, bits 7,5,4,3)
//   CRC8_POLY    : CRC-8 polynomial (x^8+x^2+x+1)
//   DEFAULT_SFD  : start-of-frame delimiter
//   crc8_step()  : one-bit MSB-first CRC-8 update
package uwb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    CRC
  } ser_state_t;

  localparam logic [7:0] LFSR_TAPS   = 8'hB8;
  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam logic [7:0] DEFAULT_SFD = 8'hA7;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/uwb_keystream_lfsr.sv
// 8-bit Fibonacci keystream LFSR gating the bit-'1' RF path.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load seed (an all-zero seed is replaced by 0x01, which
//               would otherwise lock the register at zero)
//   seed      : seed value
//   advance   : step the register once
//   key_bit   : keystream output (lfsr[0])
module uwb_keystream_lfsr
  import uwb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic       key_bit
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= '0;
    end else if (load) begin
      lfsr_q <= (seed == 8'h00) ? 8'h01 : seed;
    end else if (advance) begin
      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign key_bit = lfsr_q[0];

endmodule

// File: rtl/uwb_frame_serializer.sv
// UWB frame serializer: accepts payload bytes over valid/ready and sends
// preamble, SFD, payload (MSB first) and, when UWB_SER_CRC_EN is defined,
// a trailing CRC-8, one symbol per BIT_PERIOD clocks.
//   clk, rst        : clock, asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready : payload byte stream
//   key_seed        : keystream seed, sampled at the frame-start handshake
//   bit_out, sk_out : serial symbol and key gate to the transmitter
//   sym_strobe      : first clock of every symbol
//   busy            : frame in progress
//   frame_done      : 1-clock pulse after the final symbol
//   underrun        : 1-clock pulse when the payload runs dry
// Optional feature macro: UWB_SER_CRC_EN (CRC-8 trailer).
//
// state    | meaning
// IDLE     | waiting for the first byte of a frame
// PREAMBLE | PREAMBLE_LEN symbols of 1,0,1,0...
// SFD      | 8 delimiter symbols, MSB first
// PAYLOAD  | payload bytes, MSB first; next byte requested in bit 0
// CRC      | 8 CRC-8 symbols, MSB first (UWB_SER_CRC_EN only)
module uwb_frame_serializer
  import uwb_tx_pkg::*;
#(
  parameter int         BIT_PERIOD   = 8,
  parameter int         PREAMBLE_LEN = 16,
  parameter logic [7:0] SFD          = DEFAULT_SFD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  input  logic [7:0] key_seed,
  output logic       bit_out,
  output logic       sk_out,
  output logic       sym_strobe,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int            TW       = $clog2(BIT_PERIOD);
  localparam logic [TW-1:0] T_LAST   = TW'(BIT_PERIOD - 1);
  localparam logic [7:0]    PRE_LAST = 8'(PREAMBLE_LEN - 1);

  ser_state_t    state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [7:0]    bit_cnt_q;
  logic [7:0]    shreg_q;
  logic          last_q;
  logic          done_q, underrun_q;
  logic          armed_q;
  logic          key_bit;

  logic sym_end, accept, load_byte, cnt_clr, done_d, underrun_d, ready_c;

  assign sym_end = (timer_q == T_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ready_c    = 1'b0;
    accept     = 1'b0;
    load_byte  = 1'b0;
    cnt_clr    = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = armed_q;
        if (armed_q && s_valid) begin
          accept    = 1'b1;
          load_byte = 1'b1;
          state_d   = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (sym_end && bit_cnt_q == PRE_LAST) begin
          cnt_clr = 1'b1;
          state_d = uwb_tx_pkg::SFD;
        end
      end
      uwb_tx_pkg::SFD: begin
        if (sym_end && bit_cnt_q == 8'd7) begin
          cnt_clr = 1'b1;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (sym_end && bit_cnt_q == 8'd7) begin
          cnt_clr = 1'b1;
          if (last_q) begin
`ifdef UWB_SER_CRC_EN
            state_d = CRC;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            // Request the next byte in the last clock of bit 0 so the
            // following byte starts without a gap symbol.
            ready_c = 1'b1;
            if (s_valid) begin
              load_byte = 1'b1;
            end else begin
              state_d    = IDLE;
              underrun_d = 1'b1;
            end
          end
        end
      end
`ifdef UWB_SER_CRC_EN
      CRC: begin
        if (sym_end && bit_cnt_q == 8'd7) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      if (state_q == IDLE || sym_end) timer_q <= '0;
      else                             timer_q <= timer_q + 1'b1;
      if (state_q == IDLE || cnt_clr) bit_cnt_q <= '0;
      else if (sym_end)                bit_cnt_q <= bit_cnt_q + 8'd1;
      if (load_byte) begin
        shreg_q <= s_data;
        last_q  <= s_last;
      end else if (state_q == PAYLOAD && sym_end) begin
        shreg_q <= {shreg_q[6:0], 1'b0};
      end
    end
  end

`ifdef UWB_SER_CRC_EN
  logic [7:0] crc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= '0;
    end else if (accept) begin
      crc_q <= '0;
    end else if (state_q == PAYLOAD && sym_end) begin
      crc_q <= crc8_step(crc_q, shreg_q[7]);
    end else if (state_q == CRC && sym_end) begin
      crc_q <= {crc_q[6:0], 1'b0};
    end
  end
`endif

  // Stepping at the end of each payload symbol keeps sk_out constant for
  // the whole symbol; payload symbol k uses the seed advanced k times.
  uwb_keystream_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .seed    (key_seed),
    .advance (state_q == PAYLOAD && sym_end),
    .key_bit (key_bit)
  );

  always_comb begin
    bit_out = 1'b0;
    sk_out  = 1'b0;
    case (state_q)
      PREAMBLE: begin
        bit_out = ~bit_cnt_q[0];
        sk_out  = 1'b1;
      end
      uwb_tx_pkg::SFD: begin
        bit_out = SFD[~bit_cnt_q[2:0]];
        sk_out  = 1'b1;
      end
      PAYLOAD: begin
        bit_out = shreg_q[7];
        sk_out  = key_bit;
      end
`ifdef UWB_SER_CRC_EN
      CRC: begin
        bit_out = crc_q[7];
        sk_out  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign s_ready    = ready_c;
  assign sym_strobe = (state_q != IDLE) && (timer_q == '0);
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_uwb_frame_serializer.sv
module tb_uwb_frame_serializer;

  localparam int BP = 4;
`ifdef UWB_SER_CRC_EN
  localparam int CRC_SYMS = 8;
`else
  localparam int CRC_SYMS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] key_seed = '0;
  logic       bit_out, sk_out, sym_strobe, busy, frame_done, underrun;

  uwb_frame_serializer #(.BIT_PERIOD(BP), .PREAMBLE_LEN(16), .SFD(8'hA7)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .key_seed(key_seed), .bit_out(bit_out), .sk_out(sk_out),
    .sym_strobe(sym_strobe), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] seed;
    logic [7:0] crc;
    logic [7:0] sk_gold;  // first 8 payload sk_out bits, symbol 0 in MSB
  } vec_t;

  vec_t vecs[4];

  int n_checks = 0;
  int n_err = 0;

  logic [7:0] tx_bytes[4];
  logic       sym_bit[256];
  logic       sym_sk[256];
  int n_sym, first_c, done_c, under_c, ready_pulses, ready_wide, stable_err, wait_c;
  logic done_busy, done_ready, under_bit, under_sk, under_busy, under_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input int k, input int n, input logic [7:0] crc);
    logic [7:0] b;
    int j;
    if (k < 16) return (k % 2 == 0);
    if (k < 24) begin
      b = 8'hA7;
      return b[3'(7 - (k - 16))];
    end
    j = k - 24;
    if (j < 8 * n) begin
      b = tx_bytes[j / 8];
      return b[3'(7 - (j % 8))];
    end
    b = crc;
    return b[3'(7 - (j - 8 * n))];
  endfunction

  task automatic drive_byte(input int idx, input int nbytes, input int withhold);
    if (idx < nbytes && idx != withhold) begin
      s_valid = 1'b1;
      s_data  = tx_bytes[idx];
      s_last  = (idx == nbytes - 1);
    end else begin
      s_valid = 1'b0;
      s_data  = 8'hEE;
      s_last  = 1'b1;
    end
  endtask

  task automatic run_frame(input int nbytes, input int withhold, input logic [7:0] seed,
                           input int abort_at);
    int idx;
    bit fin;
    logic got_ready, prev_ready, cur_b, cur_k;
    n_sym = 0; first_c = -1; done_c = -1; under_c = -1;
    ready_pulses = 0; ready_wide = 0; stable_err = 0; wait_c = 0;
    while (!s_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    chk("idle_ready", 32'(s_ready), 32'd1);
    s_data = tx_bytes[0]; s_last = (nbytes == 1); s_valid = 1'b1; key_seed = seed;
    @(posedge clk); #1;
    key_seed = 8'h5C;
    idx = 1;
    drive_byte(idx, nbytes, withhold);
    fin = 1'b0; prev_ready = 1'b0; cur_b = 1'b0; cur_k = 1'b0;
    for (int c = 1; c <= 3000 && !fin; c++) begin
      @(negedge clk);
      if (sym_strobe) begin
        if (first_c < 0) first_c = c;
        if (n_sym < 256) begin
          sym_bit[n_sym] = bit_out;
          sym_sk[n_sym]  = sk_out;
        end
        n_sym++;
        cur_b = bit_out; cur_k = sk_out;
      end else if (busy && (bit_out !== cur_b || sk_out !== cur_k)) begin
        stable_err++;
      end
      got_ready = s_ready && busy;
      if (got_ready) begin
        ready_pulses++;
        if (prev_ready) ready_wide++;
      end
      prev_ready = got_ready;
      if (underrun) begin
        under_c = c; under_bit = bit_out; under_sk = sk_out;
        under_busy = busy; under_done = frame_done; fin = 1'b1;
      end else if (frame_done) begin
        done_c = c; done_busy = busy; done_ready = s_ready; fin = 1'b1;
      end else if (c == abort_at) begin
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        if (got_ready && s_valid) begin
          idx++;
          drive_byte(idx, nbytes, withhold);
        end
      end
    end
    if (!fin) chk("frame_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int nbytes, input logic [7:0] crc,
                             input logic [7:0] sk_gold);
    int nexp, bad;
    logic [7:0] skp;
    nexp = 24 + 8 * nbytes + CRC_SYMS;
    chk({tag, "_first_strobe"}, 32'(first_c), 32'd1);
    chk({tag, "_nsym"}, 32'(n_sym), 32'(nexp));
    bad = -1;
    for (int k = 0; k < nexp && k < n_sym && k < 256; k++) begin
      if (bad < 0 && sym_bit[k] !== exp_bit(k, nbytes, crc)) bad = k;
      if (bad < 0 && (k < 24 || k >= 24 + 8 * nbytes) && sym_sk[k] !== 1'b1) bad = k;
    end
    chk({tag, "_stream_first_bad_symbol"}, 32'(bad), 32'hFFFF_FFFF);
    chk({tag, "_length_clocks"}, 32'(done_c - first_c), 32'(nexp * BP));
    chk({tag, "_busy_at_done"}, 32'(done_busy), 32'd0);
    chk({tag, "_ready_at_done"}, 32'(done_ready), 32'd1);
    chk({tag, "_mid_symbol_changes"}, 32'(stable_err), 32'd0);
    chk({tag, "_ready_pulses"}, 32'(ready_pulses), 32'(nbytes - 1));
    chk({tag, "_ready_wide"}, 32'(ready_wide), 32'd0);
    for (int k = 0; k < 8; k++) skp[7 - k] = sym_sk[24 + k];
    chk({tag, "_payload_sk"}, 32'(skp), 32'(sk_gold));
  endtask

  initial begin
    int pulses;
    vecs[0] = '{data: 8'h5A, seed: 8'h01, crc: 8'h81, sk_gold: 8'b1000_1110};
    vecs[1] = '{data: 8'h00, seed: 8'h00, crc: 8'h00, sk_gold: 8'b1000_1110};
    vecs[2] = '{data: 8'hFF, seed: 8'hFF, crc: 8'hF3, sk_gold: 8'b1000_0101};
    vecs[3] = '{data: 8'h3C, seed: 8'h80, crc: 8'hB4, sk_gold: 8'b0100_0111};

    // reset state and release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({s_ready, bit_out, sk_out, sym_strobe, busy, frame_done, underrun}), 32'd0);
    #2 rst = 1'b1;
    #1 chk("ready_before_first_clk", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_release", 32'(s_ready), 32'd1);

    // single-byte frames, chained so every later frame is offered in the
    // frame_done cycle of the previous one
    for (int i = 0; i < 4; i++) begin
      tx_bytes[0] = vecs[i].data;
      run_frame(1, -1, vecs[i].seed, 0);
      check_frame($sformatf("vec%0d", i), 1, vecs[i].crc, vecs[i].sk_gold);
      if (i > 0) chk($sformatf("vec%0d_back_to_back", i), 32'(wait_c), 32'd0);
    end

    // three bytes held valid: two one-clock requests, contiguous payload
    tx_bytes[0] = 8'h00; tx_bytes[1] = 8'hFF; tx_bytes[2] = 8'h3C;
    run_frame(3, -1, 8'h01, 0);
    check_frame("multi", 3, 8'h63, 8'b1000_1110);

    // second byte withheld -> underrun
    tx_bytes[0] = 8'h5A; tx_bytes[1] = 8'h11;
    run_frame(2, 1, 8'h01, 0);
    chk("underrun_seen", 32'(under_c > 0), 32'd1);
    chk("underrun_time", 32'(under_c - first_c), 32'(32 * BP));
    chk("underrun_nsym", 32'(n_sym), 32'd32);
    chk("underrun_bit_sk", 32'({under_bit, under_sk}), 32'd0);
    chk("underrun_busy", 32'(under_busy), 32'd0);
    chk("underrun_no_done", 32'(under_done), 32'd0);
    chk("underrun_ready_pulses", 32'(ready_pulses), 32'd1);
    @(posedge clk); #1;
    chk("underrun_pulse_width", 32'({underrun, frame_done}), 32'd0);

    // next frame after an underrun is normal
    tx_bytes[0] = 8'h5A;
    run_frame(1, -1, 8'h01, 0);
    check_frame("after_underrun", 1, 8'h81, 8'b1000_1110);

    // reset mid-payload (cycle 110 lies in the payload symbols 97..128)
    tx_bytes[0] = 8'hFF;
    run_frame(1, -1, 8'h01, 110);
    chk("pre_reset_payload", 32'({busy, bit_out}), 32'b11);
    #2 rst = 1'b0;
    #1 chk("mid_reset_outputs",
           32'({s_ready, bit_out, sk_out, sym_strobe, busy, frame_done, underrun}), 32'd0);
    @(posedge clk); #1;
    chk("held_reset_outputs",
        32'({s_ready, bit_out, sk_out, sym_strobe, busy, frame_done, underrun}), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("ready_before_clk_after_rst", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_rst", 32'({s_ready, busy}), 32'b10);
    pulses = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (frame_done || underrun || busy) pulses++;
    end
    chk("quiet_after_rst", 32'(pulses), 32'd0);

    tx_bytes[0] = 8'h5A;
    run_frame(1, -1, 8'h00, 0);
    check_frame("after_rst", 1, 8'h81, 8'b1000_1110);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
